// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register: captures decoder controls and ID operands for the EX stage, with
// stall (hold), flush (bubble) and a saturating bubble counter. Define IDEX_SHAMT_EN to register shamt.
module id_ex_pipe_reg #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall_e,
  input  logic             flush_e,
  input  logic [2:0]       alu_control_d,
  input  logic             shift_d,
  input  logic             jr_d,
  input  logic             reg_write_d,
  input  logic             mem_to_reg_d,
  input  logic             mem_write_d,
  input  logic             alu_src_d,
  input  logic             reg_dst_d,
  input  logic [WIDTH-1:0] rd1_d,
  input  logic [WIDTH-1:0] rd2_d,
  input  logic [WIDTH-1:0] sign_imm_d,
  input  logic [WIDTH-1:0] pc_plus4_d,
  input  logic [4:0]       rs_d,
  input  logic [4:0]       rt_d,
  input  logic [4:0]       rd_d,
  input  logic [4:0]       shamt_d,
  output logic [2:0]       alu_control_e,
  output logic             shift_e,
  output logic             jr_e,
  output logic             reg_write_e,
  output logic             mem_to_reg_e,
  output logic             mem_write_e,
  output logic             alu_src_e,
  output logic             reg_dst_e,
  output logic [WIDTH-1:0] rd1_e,
  output logic [WIDTH-1:0] rd2_e,
  output logic [WIDTH-1:0] sign_imm_e,
  output logic [WIDTH-1:0] pc_plus4_e,
  output logic [4:0]       rs_e,
  output logic [4:0]       rt_e,
  output logic [4:0]       rd_e,
  output logic [4:0]       shamt_e,
  output logic             valid_e,
  output logic [CNT_W-1:0] bubble_cnt
);

  // Everything that travels ID -> EX; an all-zero value is a bubble.
  typedef struct packed {
    logic [2:0]       alu_control;
    logic             shift;
    logic             jr;
    logic             reg_write;
    logic             mem_to_reg;
    logic             mem_write;
    logic             alu_src;
    logic             reg_dst;
    logic [WIDTH-1:0] rd1;
    logic [WIDTH-1:0] rd2;
    logic [WIDTH-1:0] sign_imm;
    logic [WIDTH-1:0] pc_plus4;
    logic [4:0]       rs;
    logic [4:0]       rt;
    logic [4:0]       rd;
  } stage_t;

  stage_t d_stage;
  stage_t e_q;
  logic   valid_q;

  always_comb begin
    d_stage             = '0;
    d_stage.alu_control = alu_control_d;
    d_stage.shift       = shift_d;
    d_stage.jr          = jr_d;
    d_stage.reg_write   = reg_write_d;
    d_stage.mem_to_reg  = mem_to_reg_d;
    d_stage.mem_write   = mem_write_d;
    d_stage.alu_src     = alu_src_d;
    d_stage.reg_dst     = reg_dst_d;
    d_stage.rd1         = rd1_d;
    d_stage.rd2         = rd2_d;
    d_stage.sign_imm    = sign_imm_d;
    d_stage.pc_plus4    = pc_plus4_d;
    d_stage.rs          = rs_d;
    d_stage.rt          = rt_d;
    d_stage.rd          = rd_d;
  end

  // Flush beats stall so a squashed instruction cannot be held in EX.
  // NOTE: non-blocking (<=) for all flop state; the missing final else is a clock enable
  // (hold), not a latch, because this is an edge-triggered always_ff.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_q     <= '0;
      valid_q <= 1'b0;
    end else if (flush_e) begin
      e_q     <= '0;
      valid_q <= 1'b0;
    end else if (!stall_e) begin
      e_q     <= d_stage;
      valid_q <= 1'b1;
    end
  end

  // Counts every flush edge, stalled or not, and sticks at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bubble_cnt <= '0;
    end else if (flush_e && (bubble_cnt != {CNT_W{1'b1}})) begin
      bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end

`ifdef IDEX_SHAMT_EN
  logic [4:0] shamt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shamt_q <= '0;
    end else if (flush_e) begin
      shamt_q <= '0;
    end else if (!stall_e) begin
      shamt_q <= shamt_d;
    end
  end

  assign shamt_e = shamt_q;
`else
  // EX takes the shift amount from sign_imm_e[10:6] in this build.
  logic unused_shamt;
  assign unused_shamt = ^shamt_d;
  assign shamt_e      = 5'd0;
`endif

  assign alu_control_e = e_q.alu_control;
  assign shift_e       = e_q.shift;
  assign jr_e          = e_q.jr;
  assign reg_write_e   = e_q.reg_write;
  assign mem_to_reg_e  = e_q.mem_to_reg;
  assign mem_write_e   = e_q.mem_write;
  assign alu_src_e     = e_q.alu_src;
  assign reg_dst_e     = e_q.reg_dst;
  assign rd1_e         = e_q.rd1;
  assign rd2_e         = e_q.rd2;
  assign sign_imm_e    = e_q.sign_imm;
  assign pc_plus4_e    = e_q.pc_plus4;
  assign rs_e          = e_q.rs;
  assign rt_e          = e_q.rt;
  assign rd_e          = e_q.rd;
  assign valid_e       = valid_q;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Self-checking bench for id_ex_pipe_reg: spec-level model checked every negedge plus directed
// literal checks. A second instance with CNT_W=2 exercises counter saturation.
module tb_id_ex_pipe_reg;

  localparam int WIDTH = 32;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall_e, flush_e;
  logic [2:0]  alu_control_d;
  logic        shift_d, jr_d, reg_write_d, mem_to_reg_d, mem_write_d, alu_src_d, reg_dst_d;
  logic [31:0] rd1_d, rd2_d, sign_imm_d, pc_plus4_d;
  logic [4:0]  rs_d, rt_d, rd_d, shamt_d;

  logic [2:0]  alu_control_e, s_alu_control_e;
  logic        shift_e, jr_e, reg_write_e, mem_to_reg_e, mem_write_e, alu_src_e, reg_dst_e, valid_e;
  logic        s_shift_e, s_jr_e, s_reg_write_e, s_mem_to_reg_e, s_mem_write_e, s_alu_src_e;
  logic        s_reg_dst_e, s_valid_e;
  logic [31:0] rd1_e, rd2_e, sign_imm_e, pc_plus4_e, s_rd1_e, s_rd2_e, s_sign_imm_e, s_pc_plus4_e;
  logic [4:0]  rs_e, rt_e, rd_e, shamt_e, s_rs_e, s_rt_e, s_rd_e, s_shamt_e;
  logic [15:0] bubble_cnt;
  logic [1:0]  s_bubble_cnt;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  id_ex_pipe_reg #(.WIDTH(WIDTH), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .stall_e(stall_e), .flush_e(flush_e),
    .alu_control_d(alu_control_d), .shift_d(shift_d), .jr_d(jr_d), .reg_write_d(reg_write_d),
    .mem_to_reg_d(mem_to_reg_d), .mem_write_d(mem_write_d), .alu_src_d(alu_src_d),
    .reg_dst_d(reg_dst_d), .rd1_d(rd1_d), .rd2_d(rd2_d), .sign_imm_d(sign_imm_d),
    .pc_plus4_d(pc_plus4_d), .rs_d(rs_d), .rt_d(rt_d), .rd_d(rd_d), .shamt_d(shamt_d),
    .alu_control_e(alu_control_e), .shift_e(shift_e), .jr_e(jr_e), .reg_write_e(reg_write_e),
    .mem_to_reg_e(mem_to_reg_e), .mem_write_e(mem_write_e), .alu_src_e(alu_src_e),
    .reg_dst_e(reg_dst_e), .rd1_e(rd1_e), .rd2_e(rd2_e), .sign_imm_e(sign_imm_e),
    .pc_plus4_e(pc_plus4_e), .rs_e(rs_e), .rt_e(rt_e), .rd_e(rd_e), .shamt_e(shamt_e),
    .valid_e(valid_e), .bubble_cnt(bubble_cnt)
  );

  id_ex_pipe_reg #(.WIDTH(WIDTH), .CNT_W(2)) dut_small (
    .clk(clk), .reset(reset), .stall_e(stall_e), .flush_e(flush_e),
    .alu_control_d(alu_control_d), .shift_d(shift_d), .jr_d(jr_d), .reg_write_d(reg_write_d),
    .mem_to_reg_d(mem_to_reg_d), .mem_write_d(mem_write_d), .alu_src_d(alu_src_d),
    .reg_dst_d(reg_dst_d), .rd1_d(rd1_d), .rd2_d(rd2_d), .sign_imm_d(sign_imm_d),
    .pc_plus4_d(pc_plus4_d), .rs_d(rs_d), .rt_d(rt_d), .rd_d(rd_d), .shamt_d(shamt_d),
    .alu_control_e(s_alu_control_e), .shift_e(s_shift_e), .jr_e(s_jr_e),
    .reg_write_e(s_reg_write_e), .mem_to_reg_e(s_mem_to_reg_e), .mem_write_e(s_mem_write_e),
    .alu_src_e(s_alu_src_e), .reg_dst_e(s_reg_dst_e), .rd1_e(s_rd1_e), .rd2_e(s_rd2_e),
    .sign_imm_e(s_sign_imm_e), .pc_plus4_e(s_pc_plus4_e), .rs_e(s_rs_e), .rt_e(s_rt_e),
    .rd_e(s_rd_e), .shamt_e(s_shamt_e), .valid_e(s_valid_e), .bubble_cnt(s_bubble_cnt)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the EX view is simply "last loaded ID word", "empty", or "held".
  logic [9:0]   m_ctrl;
  logic [127:0] m_data;
  logic [19:0]  m_regs;
  logic         m_valid;
  int           m_cnt, m_cnt_small;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_ctrl <= '0; m_data <= '0; m_regs <= '0; m_valid <= 1'b0;
      m_cnt <= 0; m_cnt_small <= 0;
    end else begin
      if (flush_e) begin
        m_ctrl <= '0; m_data <= '0; m_regs <= '0; m_valid <= 1'b0;
        m_cnt       <= (m_cnt + 1 > 65535) ? 65535 : m_cnt + 1;
        m_cnt_small <= (m_cnt_small + 1 > 3) ? 3 : m_cnt_small + 1;
      end else if (!stall_e) begin
        m_ctrl  <= {alu_control_d, shift_d, jr_d, reg_write_d, mem_to_reg_d, mem_write_d,
                    alu_src_d, reg_dst_d};
        m_data  <= {rd1_d, rd2_d, sign_imm_d, pc_plus4_d};
`ifdef IDEX_SHAMT_EN
        m_regs  <= {rs_d, rt_d, rd_d, shamt_d};
`else
        m_regs  <= {rs_d, rt_d, rd_d, 5'd0};
`endif
        m_valid <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    check("ctrl", {alu_control_e, shift_e, jr_e, reg_write_e, mem_to_reg_e, mem_write_e,
                   alu_src_e, reg_dst_e}, m_ctrl);
    check("rd1", rd1_e, m_data[127:96]);
    check("rd2", rd2_e, m_data[95:64]);
    check("sign_imm", sign_imm_e, m_data[63:32]);
    check("pc_plus4", pc_plus4_e, m_data[31:0]);
    check("regs", {rs_e, rt_e, rd_e, shamt_e}, m_regs);
    check("valid", valid_e, m_valid);
    check("bubble_cnt", bubble_cnt, m_cnt);
    check("bubble_cnt_small", s_bubble_cnt, m_cnt_small);
    if (!valid_e) check("bubble_no_write", {reg_write_e, mem_write_e, jr_e}, 3'b000);
  end

  task automatic clear_d();
    {alu_control_d, shift_d, jr_d, reg_write_d, mem_to_reg_d, mem_write_d, alu_src_d,
     reg_dst_d} = '0;
    {rd1_d, rd2_d, sign_imm_d, pc_plus4_d} = '0;
    {rs_d, rt_d, rd_d, shamt_d} = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [4:0] exp_shamt;
    stall_e = 1'b0; flush_e = 1'b0;
    clear_d();
    tick(); tick();
    reset = 1'b0;
    check("reset_valid", valid_e, 1'b0);
    check("reset_cnt", bubble_cnt, 16'd0);

    // ADD r3 = 5 + 7
    alu_control_d = 3'b010; reg_write_d = 1'b1; reg_dst_d = 1'b1;
    rd1_d = 32'd5; rd2_d = 32'd7; rs_d = 5'd1; rt_d = 5'd2; rd_d = 5'd3; pc_plus4_d = 32'h104;
    tick();
    check("add_alu_control", alu_control_e, 3'b010);
    check("add_reg_write", reg_write_e, 1'b1);
    check("add_rd1", rd1_e, 32'd5);
    check("add_rd2", rd2_e, 32'd7);
    check("add_rd", rd_e, 5'd3);
    check("add_valid", valid_e, 1'b1);

    // Stall three cycles while ID keeps changing
    stall_e = 1'b1;
    for (int i = 0; i < 3; i++) begin
      alu_control_d = 3'(i + 3); rd1_d = 32'(100 + i); rd2_d = 32'(200 + i); rd_d = 5'(10 + i);
      reg_write_d = i[0]; mem_write_d = 1'b1;
      tick();
      check("stall_rd1", rd1_e, 32'd5);
      check("stall_alu_control", alu_control_e, 3'b010);
      check("stall_valid", valid_e, 1'b1);
      check("stall_cnt", bubble_cnt, 16'd0);
    end
    stall_e = 1'b0;

    // SW: mem_write, no reg_write
    clear_d();
    alu_control_d = 3'b010; mem_write_d = 1'b1; alu_src_d = 1'b1;
    rd1_d = 32'h1000; rd2_d = 32'hdead_beef; sign_imm_d = 32'h8; rs_d = 5'd4; rt_d = 5'd5;
    tick();
    check("sw_mem_write", mem_write_e, 1'b1);

    // Flush wins over stall
    stall_e = 1'b1; flush_e = 1'b1;
    tick();
    check("flush_stall_mem_write", mem_write_e, 1'b0);
    check("flush_stall_valid", valid_e, 1'b0);
    check("flush_stall_rd2", rd2_e, 32'd0);
    check("flush_stall_cnt", bubble_cnt, 16'd1);
    stall_e = 1'b0; flush_e = 1'b0;

    // Reload, then reset away from any clock edge
    clear_d();
    alu_control_d = 3'b110; reg_write_d = 1'b1; jr_d = 1'b1; rd1_d = 32'h55; rd_d = 5'd9;
    tick();
    check("preload_valid", valid_e, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_alu_control", alu_control_e, 3'b000);
    check("async_rst_jr", jr_e, 1'b0);
    check("async_rst_rd1", rd1_e, 32'd0);
    check("async_rst_valid", valid_e, 1'b0);
    check("async_rst_cnt", bubble_cnt, 16'd0);
    tick();
    reset = 1'b0;
    tick();

    // Five flushes: 2-bit counter saturates at 3
    flush_e = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("sat_cnt_small", s_bubble_cnt, (i < 3) ? 2'(i + 1) : 2'd3);
      check("sat_cnt", bubble_cnt, 16'(i + 1));
    end
    flush_e = 1'b0;

    // SLL by 4
    clear_d();
    shift_d = 1'b1; alu_control_d = 3'b011; reg_write_d = 1'b1; reg_dst_d = 1'b1;
    rt_d = 5'd6; rd_d = 5'd7; rd2_d = 32'h3; shamt_d = 5'd4; sign_imm_d = 32'h0000_3900 | (32'd4 << 6);
`ifdef IDEX_SHAMT_EN
    exp_shamt = 5'd4;
`else
    exp_shamt = 5'd0;
`endif
    tick();
    check("sll_shift", shift_e, 1'b1);
    check("sll_shamt", shamt_e, exp_shamt);
    check("sll_imm_shamt", sign_imm_e[10:6], 5'd4);
    check("sll_valid", valid_e, 1'b1);

    clear_d();
    tick(); tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
